// File: rtl/psx_poller.sv
// PlayStation controller poller: 5-byte 0x01/0x42 transaction, returns ID and button bytes.
// Build option PSX_POLL_AUTO_EN adds a free-running auto-poll timer (POLL_PERIOD cycles).
module psx_poller #(
    parameter int unsigned CLK_DIV     = 50,
    parameter int unsigned ACK_TIMEOUT = 2000,
    parameter int unsigned POLL_PERIOD = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        data,
    input  logic        ack,
    output logic        psx_clk,
    output logic        att,
    output logic        cmd,
    output logic        busy,
    output logic        valid,
    output logic        err,
    output logic [7:0]  id,
    output logic [15:0] buttons
);
    localparam int unsigned DivW = $clog2(CLK_DIV);
    localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + CLK_DIV + 1);

    typedef enum logic [2:0] {
        StIdle, StSetup, StBitLo, StBitHi, StAckWait, StHold, StDone
    } state_t;

    state_t          state;
    logic [DivW-1:0] div_cnt;
    logic [TmoW-1:0] tmo_cnt;
    logic [2:0]      bit_idx;
    logic [2:0]      byte_idx;
    logic            ack_seen;
    logic [7:0]      rx_sr;
    logic [7:0]      byte1, byte2, byte3, byte4;
    logic            data_s1, data_s2, ack_s1, ack_s2;
    logic            start_req;

    function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    cmd_byte = 8'h01;
            3'd1:    cmd_byte = 8'h42;
            default: cmd_byte = 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
            ack_s1  <= 1'b1;
            ack_s2  <= 1'b1;
        end else begin
            data_s1 <= data;
            data_s2 <= data_s1;
            ack_s1  <= ack;
            ack_s2  <= ack_s1;
        end
    end

`ifdef PSX_POLL_AUTO_EN
    localparam int unsigned PollW = $clog2(POLL_PERIOD);
    logic [PollW-1:0] poll_cnt;
    logic             auto_start;

    assign auto_start = (poll_cnt == PollW'(POLL_PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_cnt <= '0;
        end else if (auto_start) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    // Only accepted in idle, so an auto start while busy is simply dropped.
    assign start_req = start | auto_start;
`else
    assign start_req = start;
`endif

    logic       div_done;
    logic       last_bit;
    logic       ack_track;
    logic [2:0] next_bit;
    logic [2:0] next_byte;
    logic [7:0] cur_cmd;
    logic [7:0] nxt_cmd;
    logic [7:0] rx_next;

    assign div_done  = (div_cnt == DivW'(CLK_DIV - 1));
    assign last_bit  = (bit_idx == 3'd7);
    assign next_bit  = bit_idx + 3'd1;
    assign next_byte = byte_idx + 3'd1;
    assign cur_cmd   = cmd_byte(byte_idx);
    assign nxt_cmd   = cmd_byte(next_byte);
    assign rx_next   = {data_s2, rx_sr[7:1]};
    assign ack_track = (state == StAckWait) ||
                       (last_bit && (state == StBitLo || state == StBitHi));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            psx_clk  <= 1'b1;
            att      <= 1'b1;
            cmd      <= 1'b1;
            busy     <= 1'b0;
            valid    <= 1'b0;
            err      <= 1'b0;
            id       <= 8'hFF;
            buttons  <= 16'hFFFF;
            div_cnt  <= '0;
            tmo_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            ack_seen <= 1'b0;
            rx_sr    <= '0;
            byte1    <= '0;
            byte2    <= '0;
            byte3    <= '0;
            byte4    <= '0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (ack_track && !ack_s2) ack_seen <= 1'b1;
            case (state)
                StIdle: begin
                    if (start_req) begin
                        att      <= 1'b0;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                        state    <= StSetup;
                    end
                end
                StSetup: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        psx_clk <= 1'b0;
                        cmd     <= cur_cmd[bit_idx];
                        state   <= StBitLo;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                StBitLo: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        psx_clk <= 1'b1;
                        rx_sr   <= rx_next;
                        state   <= StBitHi;
                        if (last_bit) begin
                            tmo_cnt <= '0;
                            case (byte_idx)
                                3'd1:    byte1 <= rx_next;
                                3'd2:    byte2 <= rx_next;
                                3'd3:    byte3 <= rx_next;
                                3'd4:    byte4 <= rx_next;
                                default: ;
                            endcase
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                StBitHi: begin
                    if (last_bit) tmo_cnt <= tmo_cnt + 1'b1;
                    if (div_done) begin
                        div_cnt <= '0;
                        if (!last_bit) begin
                            bit_idx <= next_bit;
                            psx_clk <= 1'b0;
                            cmd     <= cur_cmd[next_bit];
                            state   <= StBitLo;
                            if (next_bit == 3'd7) ack_seen <= 1'b0;
                        end else if (byte_idx == 3'd4) begin
                            state <= StHold;
                        end else begin
                            state <= StAckWait;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                StAckWait: begin
                    if (ack_seen && ack_s2) begin
                        byte_idx <= next_byte;
                        bit_idx  <= '0;
                        div_cnt  <= '0;
                        psx_clk  <= 1'b0;
                        cmd      <= nxt_cmd[0];
                        state    <= StBitLo;
                    end else if (tmo_cnt >= TmoW'(ACK_TIMEOUT - 1)) begin
                        err     <= 1'b1;
                        att     <= 1'b1;
                        cmd     <= 1'b1;
                        busy    <= 1'b0;
                        psx_clk <= 1'b1;
                        state   <= StIdle;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                StHold: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        att     <= 1'b1;
                        cmd     <= 1'b1;
                        id      <= byte1;
                        state   <= StDone;
                        if (byte2 == 8'h5A) begin
                            buttons <= {byte4, byte3};
                            valid   <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_psx_poller.sv
// Self-checking bench for psx_poller: behavioural controller model plus outcome prediction.
// Build with PSX_POLL_AUTO_EN defined to exercise only the auto-poll timer.
module tb_psx_poller;
    localparam int CLK_DIV     = 4;
    localparam int ACK_TIMEOUT = 60;
    localparam int POLL_PERIOD = 5000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        data = 1'b1;
    logic        ack = 1'b1;
    logic        psx_clk, att, cmd, busy, valid, err;
    logic [7:0]  id;
    logic [15:0] buttons;

    int vectors = 0;
    int miscompares = 0;

    // Controller model state
    logic [7:0] tx [5];
    bit         ack_en [4];
    logic [7:0] cmd_rx [5];
    int         t_hi [5];
    int model_cyc = 0, bit_cnt = 0, byte_cnt = 0, ack_dly = 0, ack_lo = 0;
    int valid_cnt = 0, err_cnt = 0, overlap_cnt = 0, att_falls = 0;
    int t_err = 0, t_fall = 0, t_fall_prev = 0;
    logic prev_pclk = 1'b1, prev_att = 1'b1;

    logic [7:0]  exp_id = 8'hFF;
    logic [15:0] exp_buttons = 16'hFFFF;

    psx_poller #(
        .CLK_DIV    (CLK_DIV),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .POLL_PERIOD(POLL_PERIOD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .data   (data),
        .ack    (ack),
        .psx_clk(psx_clk),
        .att    (att),
        .cmd    (cmd),
        .busy   (busy),
        .valid  (valid),
        .err    (err),
        .id     (id),
        .buttons(buttons)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_cmd(input int i);
        return (i == 0) ? 8'h01 : (i == 1) ? 8'h42 : 8'h00;
    endfunction

    function automatic int first_nack();
        for (int i = 0; i < 4; i++) if (!ack_en[i]) return i;
        return -1;
    endfunction

    // Controller: shifts tx bits out on psx_clk fall, captures cmd on rise, acks selected bytes.
    always @(negedge clk) begin
        model_cyc++;
        if (valid) valid_cnt++;
        if (err) begin err_cnt++; t_err = model_cyc; end
        if (valid && err) overlap_cnt++;
        if (prev_att && !att) begin att_falls++; t_fall_prev = t_fall; t_fall = model_cyc; end
        if (att) begin
            data = 1'b1; ack = 1'b1; bit_cnt = 0; byte_cnt = 0; ack_dly = 0; ack_lo = 0;
        end else begin
            if (prev_pclk && !psx_clk && byte_cnt < 5) data = tx[byte_cnt][bit_cnt];
            if (!prev_pclk && psx_clk && byte_cnt < 5) begin
                cmd_rx[byte_cnt][bit_cnt] = cmd;
                if (bit_cnt == 7) begin
                    t_hi[byte_cnt] = model_cyc;
                    if (byte_cnt < 4 && ack_en[byte_cnt]) ack_dly = 2;
                    bit_cnt = 0;
                    byte_cnt++;
                end else begin
                    bit_cnt++;
                end
            end
            if (ack_dly > 0) begin
                ack_dly--;
                if (ack_dly == 0) ack_lo = 3;
            end else if (ack_lo > 0) begin
                ack_lo--;
            end
            ack = (ack_lo == 0);
        end
        prev_pclk = psx_clk;
        prev_att  = att;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_poll(output bit timed_out);
        int v0 = valid_cnt;
        int e0 = err_cnt;
        pulse_start();
        timed_out = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (valid_cnt != v0 || err_cnt != e0) begin timed_out = 1'b0; break; end
        end
        repeat (3) tick();
    endtask

    task automatic load_std();
        tx[0] = 8'hFF; tx[1] = 8'h41; tx[2] = 8'h5A; tx[3] = 8'h7F; tx[4] = 8'hFF;
        for (int i = 0; i < 4; i++) ack_en[i] = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        vectors++; if (psx_clk !== 1'b1) begin miscompares++; $display("FAIL rst_psx_clk got %b want 1", psx_clk); end
        vectors++; if (att !== 1'b1)     begin miscompares++; $display("FAIL rst_att got %b want 1", att); end
        vectors++; if (cmd !== 1'b1)     begin miscompares++; $display("FAIL rst_cmd got %b want 1", cmd); end
        vectors++; if (busy !== 1'b0)    begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
        vectors++; if (valid !== 1'b0)   begin miscompares++; $display("FAIL rst_valid got %b want 0", valid); end
        vectors++; if (err !== 1'b0)     begin miscompares++; $display("FAIL rst_err got %b want 0", err); end
        vectors++; if (id !== 8'hFF)     begin miscompares++; $display("FAIL rst_id got %h want ff", id); end
        vectors++; if (buttons !== 16'hFFFF) begin miscompares++; $display("FAIL rst_buttons got %h want ffff", buttons); end
        rst = 1'b0;
        exp_id = 8'hFF;
        exp_buttons = 16'hFFFF;
        repeat (5) tick();
        vectors++; if (att !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL idle_after_rst att=%b busy=%b want 1/0", att, busy); end
    endtask

    task automatic test_timeout();
        bit to;
        int e0 = err_cnt;
        int v0 = valid_cnt;
        load_std();
        ack_en[0] = 1'b0;
        run_poll(to);
        vectors++; if (to) begin miscompares++; $display("FAIL tmo_wait got no completion want err"); end
        vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL tmo_err got %0d want 1", err_cnt - e0); end
        vectors++; if (valid_cnt - v0 !== 0) begin miscompares++; $display("FAIL tmo_valid got %0d want 0", valid_cnt - v0); end
        vectors++; if (t_err - t_hi[0] !== ACK_TIMEOUT) begin miscompares++; $display("FAIL tmo_latency got %0d want %0d", t_err - t_hi[0], ACK_TIMEOUT); end
        vectors++; if (att !== 1'b1 || cmd !== 1'b1) begin miscompares++; $display("FAIL tmo_att got att=%b cmd=%b want 1/1", att, cmd); end
        vectors++; if (buttons !== 16'hFFFF) begin miscompares++; $display("FAIL tmo_buttons got %h want ffff", buttons); end
        vectors++; if (id !== exp_id) begin miscompares++; $display("FAIL tmo_id got %h want %h", id, exp_id); end
    endtask

    task automatic test_good();
        bit to;
        int v0 = valid_cnt;
        int e0 = err_cnt;
        load_std();
        run_poll(to);
        exp_id = 8'h41;
        exp_buttons = 16'hFF7F;
        vectors++; if (to) begin miscompares++; $display("FAIL good_wait got no completion want valid"); end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (cmd_rx[i] !== exp_cmd(i)) begin miscompares++; $display("FAIL good_cmd%0d got %h want %h", i, cmd_rx[i], exp_cmd(i)); end
        end
        vectors++; if (valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL good_valid got %0d want 1", valid_cnt - v0); end
        vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL good_err got %0d want 0", err_cnt - e0); end
        vectors++; if (id !== exp_id) begin miscompares++; $display("FAIL good_id got %h want %h", id, exp_id); end
        vectors++; if (buttons !== exp_buttons) begin miscompares++; $display("FAIL good_buttons got %h want %h", buttons, exp_buttons); end
        vectors++; if (busy !== 1'b0 || att !== 1'b1) begin miscompares++; $display("FAIL good_idle busy=%b att=%b want 0/1", busy, att); end
    endtask

    task automatic test_bad_header();
        bit to;
        int v0 = valid_cnt;
        int e0 = err_cnt;
        load_std();
        tx[2] = 8'hA5;
        tx[3] = 8'h12;
        run_poll(to);
        exp_id = 8'h41;
        vectors++; if (to) begin miscompares++; $display("FAIL hdr_wait got no completion want err"); end
        vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL hdr_err got %0d want 1", err_cnt - e0); end
        vectors++; if (valid_cnt - v0 !== 0) begin miscompares++; $display("FAIL hdr_valid got %0d want 0", valid_cnt - v0); end
        vectors++; if (id !== exp_id) begin miscompares++; $display("FAIL hdr_id got %h want %h", id, exp_id); end
        vectors++; if (buttons !== exp_buttons) begin miscompares++; $display("FAIL hdr_buttons got %h want %h", buttons, exp_buttons); end
    endtask

    task automatic test_random();
        bit to;
        int k, v0, e0, last;
        bit good;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 5; i++) tx[i] = 8'($urandom);
            if ($urandom_range(0, 3) != 0) tx[2] = 8'h5A;
            for (int i = 0; i < 4; i++) ack_en[i] = ($urandom_range(0, 5) != 0);
            k = first_nack();
            good = (k < 0) && (tx[2] == 8'h5A);
            v0 = valid_cnt;
            e0 = err_cnt;
            run_poll(to);
            if (k < 0) exp_id = tx[1];
            if (good) exp_buttons = {tx[4], tx[3]};
            vectors++; if (to) begin miscompares++; $display("FAIL rnd%0d_wait got no completion", n); end
            vectors++; if (valid_cnt - v0 !== int'(good)) begin miscompares++; $display("FAIL rnd%0d_valid got %0d want %0d", n, valid_cnt - v0, int'(good)); end
            vectors++; if (err_cnt - e0 !== int'(!good)) begin miscompares++; $display("FAIL rnd%0d_err got %0d want %0d", n, err_cnt - e0, int'(!good)); end
            vectors++; if (id !== exp_id) begin miscompares++; $display("FAIL rnd%0d_id got %h want %h", n, id, exp_id); end
            vectors++; if (buttons !== exp_buttons) begin miscompares++; $display("FAIL rnd%0d_buttons got %h want %h", n, buttons, exp_buttons); end
            if (k >= 0) begin
                vectors++;
                if (t_err - t_hi[k] !== ACK_TIMEOUT) begin miscompares++; $display("FAIL rnd%0d_tmo got %0d want %0d", n, t_err - t_hi[k], ACK_TIMEOUT); end
            end
            last = (k < 0) ? 4 : k;
            for (int i = 0; i <= last; i++) begin
                vectors++;
                if (cmd_rx[i] !== exp_cmd(i)) begin miscompares++; $display("FAIL rnd%0d_cmd%0d got %h want %h", n, i, cmd_rx[i], exp_cmd(i)); end
            end
            vectors++; if (att !== 1'b1 || cmd !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_idle att=%b cmd=%b busy=%b want 1/1/0", n, att, cmd, busy); end
        end
    endtask

    task automatic test_reset_mid();
        bit to, hit;
        int v0, e0;
        load_std();
        v0 = valid_cnt;
        e0 = err_cnt;
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (byte_cnt == 2 && bit_cnt == 3) begin hit = 1'b1; break; end
        end
        vectors++; if (!hit) begin miscompares++; $display("FAIL rmid_reach got no byte 2 want byte 2"); end
        #1 rst = 1'b1;
        #1;
        vectors++; if (att !== 1'b1) begin miscompares++; $display("FAIL rmid_att got %b want 1", att); end
        vectors++; if (busy !== 1'b0 || psx_clk !== 1'b1 || cmd !== 1'b1) begin miscompares++; $display("FAIL rmid_outs busy=%b psx_clk=%b cmd=%b want 0/1/1", busy, psx_clk, cmd); end
        repeat (3) tick();
        rst = 1'b0;
        exp_id = 8'hFF;
        exp_buttons = 16'hFFFF;
        repeat (10) tick();
        vectors++; if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin miscompares++; $display("FAIL rmid_pulses valid=%0d err=%0d want 0/0", valid_cnt - v0, err_cnt - e0); end
        vectors++; if (id !== exp_id || buttons !== exp_buttons) begin miscompares++; $display("FAIL rmid_regs id=%h buttons=%h want ff/ffff", id, buttons); end
        tx[3] = 8'hC3;
        tx[4] = 8'h3C;
        run_poll(to);
        exp_id = tx[1];
        exp_buttons = {tx[4], tx[3]};
        vectors++; if (to || valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL rmid_next valid=%0d want 1", valid_cnt - v0); end
        vectors++; if (buttons !== exp_buttons || id !== exp_id) begin miscompares++; $display("FAIL rmid_next_regs id=%h buttons=%h want %h/%h", id, buttons, exp_id, exp_buttons); end
    endtask

    task automatic test_back_to_back();
        bit hit;
        int f0, v0, e0;
        load_std();
        f0 = att_falls;
        v0 = valid_cnt;
        e0 = err_cnt;
        pulse_start();
        repeat (10) tick();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy got %b want 1", busy); end
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (att === 1'b1) begin hit = 1'b1; break; end
        end
        vectors++; if (!hit) begin miscompares++; $display("FAIL b2b_end got no att release want release"); end
        // Now inside the one-cycle DONE window.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (600) tick();
        vectors++; if (att_falls - f0 !== 1) begin miscompares++; $display("FAIL b2b_count got %0d transactions want 1", att_falls - f0); end
        vectors++; if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin miscompares++; $display("FAIL b2b_pulses valid=%0d err=%0d want 1/0", valid_cnt - v0, err_cnt - e0); end
        vectors++; if (overlap_cnt !== 0) begin miscompares++; $display("FAIL overlap got %0d want 0", overlap_cnt); end
    endtask

    task automatic test_auto();
        int seen;
        load_std();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4 * POLL_PERIOD && seen < 3; i++) begin
            tick();
            if (att_falls != seen) begin
                seen = att_falls;
                if (seen > 1) begin
                    vectors++;
                    if (t_fall - t_fall_prev !== POLL_PERIOD) begin miscompares++; $display("FAIL auto_period got %0d want %0d", t_fall - t_fall_prev, POLL_PERIOD); end
                end
            end
        end
        vectors++; if (seen < 3) begin miscompares++; $display("FAIL auto_polls got %0d want 3", seen); end
        repeat (600) tick();
        vectors++; if (valid_cnt !== att_falls) begin miscompares++; $display("FAIL auto_valid got %0d want %0d", valid_cnt, att_falls); end
        vectors++; if (err_cnt !== 0) begin miscompares++; $display("FAIL auto_err got %0d want 0", err_cnt); end
        vectors++; if (buttons !== 16'hFF7F) begin miscompares++; $display("FAIL auto_buttons got %h want ff7f", buttons); end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin tx[i] = 8'hFF; cmd_rx[i] = 8'h00; t_hi[i] = 0; end
        for (int i = 0; i < 4; i++) ack_en[i] = 1'b1;
`ifdef PSX_POLL_AUTO_EN
        test_auto();
`else
        test_reset();
        test_timeout();
        test_good();
        test_bad_header();
        test_random();
        test_reset_mid();
        test_back_to_back();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
